// File: rtl/regblock_pkg.sv
// Shared register-block definitions.
// Holds the address width, the derived word-line count, and the typedefs
// used by the address-decode slice and its testbench.
package regblock_pkg;

   localparam int ADDR_W = 3;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DEPTH-1:0]  wl_sel_t;

endpackage : regblock_pkg

// File: rtl/onehot_dec.sv
// Combinational ADDR_W-to-DEPTH one-hot decoder with enable.
// Ports:
//   en       - 1 enables the decode; 0 forces an all-zero output
//   addr_in  - binary address, every value 0..DEPTH-1 is valid
//   sel_out  - one-hot select (bit addr_in set), or all zeros when disabled
module onehot_dec
   import regblock_pkg::*;
#(
   parameter  int ADDR_W = regblock_pkg::ADDR_W,
   localparam int DEPTH  = 2 ** ADDR_W
) (
   input  logic              en,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [DEPTH-1:0]  sel_out
);

   // Decode the address into a single asserted word line.
   always_comb begin
      sel_out = {DEPTH{1'b0}};
      if (en) begin
         sel_out[addr_in] = 1'b1;
      end else begin
         sel_out = {DEPTH{1'b0}};
      end
   end

endmodule : onehot_dec

// File: rtl/slice_17.sv
// Address-decode slice of the register block.
// Turns two read addresses and one write address into registered one-hot
// word-line selects for the register file. The write select is gated by We.
// Ports:
//   Clock      - rising-edge clock
//   nReset     - asynchronous active-low reset, clears all selects
//   Rs1In      - read port 1 address
//   Rs2In      - read port 2 address
//   RwIn       - write port address
//   We         - write enable, qualifies the write select
//   Rs1 / Rs2  - one-hot read word-line selects (one cycle after the address)
//   Rw         - one-hot write word-line select, or zero when We was low
module slice_17
   import regblock_pkg::*;
#(
   parameter  int ADDR_W = regblock_pkg::ADDR_W,
   localparam int DEPTH  = 2 ** ADDR_W
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [ADDR_W-1:0] Rs1In,
   input  logic [ADDR_W-1:0] Rs2In,
   input  logic [ADDR_W-1:0] RwIn,
   input  logic              We,
   output logic [DEPTH-1:0]  Rs1,
   output logic [DEPTH-1:0]  Rs2,
   output logic [DEPTH-1:0]  Rw
);

   logic [DEPTH-1:0] rs1_d;
   logic [DEPTH-1:0] rs2_d;
   logic [DEPTH-1:0] rw_d;
   logic [DEPTH-1:0] rs1_q;
   logic [DEPTH-1:0] rs2_q;
   logic [DEPTH-1:0] rw_q;

   // Read decoders are always enabled; the write decoder follows We.
   onehot_dec #(.ADDR_W(ADDR_W)) u_rs1_dec (
      .en      (1'b1),
      .addr_in (Rs1In),
      .sel_out (rs1_d)
   );

   onehot_dec #(.ADDR_W(ADDR_W)) u_rs2_dec (
      .en      (1'b1),
      .addr_in (Rs2In),
      .sel_out (rs2_d)
   );

   onehot_dec #(.ADDR_W(ADDR_W)) u_rw_dec (
      .en      (We),
      .addr_in (RwIn),
      .sel_out (rw_d)
   );

   // Word-line select registers, cleared immediately on reset assertion.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         rs1_q <= {DEPTH{1'b0}};
         rs2_q <= {DEPTH{1'b0}};
         rw_q  <= {DEPTH{1'b0}};
      end else begin
         rs1_q <= rs1_d;
         rs2_q <= rs2_d;
         rw_q  <= rw_d;
      end
   end

   assign Rs1 = rs1_q;
   assign Rs2 = rs2_q;
   assign Rw  = rw_q;

endmodule : slice_17

// File: tb/tb_slice_17.sv
// Directed testbench for slice_17: reset behaviour, per-port address sweeps,
// write gating, simultaneous addresses and one-cycle latency.
module tb_slice_17;
   import regblock_pkg::*;

   logic      Clock;
   logic      nReset;
   reg_addr_t Rs1In;
   reg_addr_t Rs2In;
   reg_addr_t RwIn;
   logic      We;
   wl_sel_t   Rs1;
   wl_sel_t   Rs2;
   wl_sel_t   Rw;

   int checks_cnt   = 0;
   int failures_cnt = 0;

   // Hand-written one-hot patterns for addresses 0..7.
   logic [7:0] oh_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                              8'h10, 8'h20, 8'h40, 8'h80};

   slice_17 dut (
      .Clock  (Clock),
      .nReset (nReset),
      .Rs1In  (Rs1In),
      .Rs2In  (Rs2In),
      .RwIn   (RwIn),
      .We     (We),
      .Rs1    (Rs1),
      .Rs2    (Rs2),
      .Rw     (Rw)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      nReset = 1'b0;
      Rs1In  = 3'd0;
      Rs2In  = 3'd0;
      RwIn   = 3'd0;
      We     = 1'b0;
      tick();
      tick();
      check_eq("rst_rs1", Rs1, 8'h00);
      check_eq("rst_rs2", Rs2, 8'h00);
      check_eq("rst_rw",  Rw,  8'h00);

      // Load non-zero values, then reset mid-cycle.
      nReset = 1'b1;
      Rs1In  = 3'd2;
      Rs2In  = 3'd4;
      RwIn   = 3'd5;
      We     = 1'b1;
      tick();
      check_eq("pre_rs1", Rs1, 8'h04);
      check_eq("pre_rs2", Rs2, 8'h10);
      check_eq("pre_rw",  Rw,  8'h20);
      #2;
      nReset = 1'b0;
      #1;
      check_eq("async_rs1", Rs1, 8'h00);
      check_eq("async_rs2", Rs2, 8'h00);
      check_eq("async_rw",  Rw,  8'h00);
      tick();
      check_eq("hold_rst_rs1", Rs1, 8'h00);
      check_eq("hold_rst_rw",  Rw,  8'h00);

      // Release between edges with all inputs zero; first edge loads.
      Rs1In  = 3'd0;
      Rs2In  = 3'd0;
      RwIn   = 3'd0;
      We     = 1'b0;
      #2;
      nReset = 1'b1;
      tick();
      check_eq("rel_rs1", Rs1, 8'h01);
      check_eq("rel_rs2", Rs2, 8'h01);
      check_eq("rel_rw",  Rw,  8'h00);

      // Rs1 sweep, Rs2 held at address 0.
      for (int i = 0; i < 8; i++) begin
         Rs1In = 3'(i);
         tick();
         check_eq("rs1_sweep", Rs1, oh_tbl[i]);
         check_eq("rs1_sweep_rs2", Rs2, 8'h01);
      end

      // Rs2 sweep, Rs1 held at address 7.
      for (int i = 0; i < 8; i++) begin
         Rs2In = 3'(i);
         tick();
         check_eq("rs2_sweep", Rs2, oh_tbl[i]);
         check_eq("rs2_sweep_rs1", Rs1, 8'h80);
      end

      // Write gated off.
      We = 1'b0;
      for (int i = 0; i < 8; i++) begin
         RwIn = 3'(i);
         tick();
         check_eq("rw_gated", Rw, 8'h00);
      end

      // Write enabled.
      We = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RwIn = 3'(i);
         tick();
         check_eq("rw_en", Rw, oh_tbl[i]);
      end

      // We toggle 1 -> 0 with RwIn=3.
      RwIn = 3'd3;
      We   = 1'b1;
      tick();
      check_eq("we_on", Rw, 8'h08);
      We = 1'b0;
      tick();
      check_eq("we_off", Rw, 8'h00);

      // Simultaneous identical addresses.
      Rs1In = 3'd6;
      Rs2In = 3'd6;
      RwIn  = 3'd6;
      We    = 1'b1;
      tick();
      check_eq("sim_rs1", Rs1, 8'h40);
      check_eq("sim_rs2", Rs2, 8'h40);
      check_eq("sim_rw",  Rw,  8'h40);

      // Inputs change between edges: outputs hold until the next edge.
      #2;
      Rs1In = 3'd1;
      Rs2In = 3'd3;
      RwIn  = 3'd0;
      We    = 1'b1;
      #2;
      check_eq("hold_rs1", Rs1, 8'h40);
      check_eq("hold_rs2", Rs2, 8'h40);
      check_eq("hold_rw",  Rw,  8'h40);
      tick();
      check_eq("next_rs1", Rs1, 8'h02);
      check_eq("next_rs2", Rs2, 8'h08);
      check_eq("next_rw",  Rw,  8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule : tb_slice_17
